// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, their response ports and the shared ALU connection.
// Optional ALU_ARB_LOCK_EN adds the per-port lock inputs.
interface alu_arbiter_if #(
    parameter int DW   = 8,
    parameter int CMDW = 3
);
    logic            req0_valid, req0_ready, req0_ci;
    logic [CMDW-1:0] req0_cmd;
    logic [DW-1:0]   req0_a, req0_b;
    logic            req1_valid, req1_ready, req1_ci;
    logic [CMDW-1:0] req1_cmd;
    logic [DW-1:0]   req1_a, req1_b;
`ifdef ALU_ARB_LOCK_EN
    logic            req0_lock, req1_lock;
`endif
    logic            rsp0_valid, rsp0_ready, rsp0_co, rsp0_pari;
    logic [DW-1:0]   rsp0_rslt;
    logic            rsp1_valid, rsp1_ready, rsp1_co, rsp1_pari;
    logic [DW-1:0]   rsp1_rslt;
    logic [CMDW-1:0] alu_cmd;
    logic [DW-1:0]   alu_inA, alu_inB, alu_rslt;
    logic            alu_sc_i, alu_sc_o, alu_pari;
    logic            busy;

    modport slave (
        input  req0_valid, req0_cmd, req0_a, req0_b, req0_ci,
        input  req1_valid, req1_cmd, req1_a, req1_b, req1_ci,
`ifdef ALU_ARB_LOCK_EN
        input  req0_lock, req1_lock,
`endif
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rslt, rsp0_co, rsp0_pari,
        output rsp1_valid, rsp1_rslt, rsp1_co, rsp1_pari,
        input  rsp0_ready, rsp1_ready,
        output alu_cmd, alu_inA, alu_inB, alu_sc_i,
        input  alu_rslt, alu_sc_o, alu_pari,
        output busy
    );

    modport master (
        output req0_valid, req0_cmd, req0_a, req0_b, req0_ci,
        output req1_valid, req1_cmd, req1_a, req1_b, req1_ci,
`ifdef ALU_ARB_LOCK_EN
        output req0_lock, req1_lock,
`endif
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rslt, rsp0_co, rsp0_pari,
        input  rsp1_valid, rsp1_rslt, rsp1_co, rsp1_pari,
        output rsp0_ready, rsp1_ready,
        input  alu_cmd, alu_inA, alu_inB, alu_sc_i,
        output alu_rslt, alu_sc_o, alu_pari,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: IDLE -> EXEC -> RESP.
// Define ALU_ARB_LOCK_EN to let an owner hold the grant across locked operations.
module alu_arbiter #(
    parameter int DW   = 8,
    parameter int CMDW = 3
) (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_last, r_owner, r_ci;
    logic [CMDW-1:0]     r_cmd;
    logic [DW-1:0]       r_a, r_b;
    logic [1:0][DW-1:0]  r_rslt;
    logic [1:0]          r_co, r_pari;
    logic                w_gnt0, w_gnt1, w_rdy0, w_rdy1, w_acc;
`ifdef ALU_ARB_LOCK_EN
    logic                r_lock;
`endif

    // r_last is the last granted port; on a tie the other port wins.
    always_comb begin
        w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last);
        w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last);
`ifdef ALU_ARB_LOCK_EN
        if (r_lock) begin
            w_gnt0 = bus.req0_valid & ~r_owner;
            w_gnt1 = bus.req1_valid &  r_owner;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rdy0         = 1'b0;
        w_rdy1         = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.alu_cmd    = '0;
        bus.alu_inA    = '0;
        bus.alu_inB    = '0;
        bus.alu_sc_i   = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_rdy0 = w_gnt0 & ~reset;
                w_rdy1 = w_gnt1 & ~reset;
                if (w_rdy0 | w_rdy1) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                bus.alu_cmd  = r_cmd;
                bus.alu_inA  = r_a;
                bus.alu_inB  = r_b;
                bus.alu_sc_i = r_ci;
                w_state_nxt  = S_RESP;
            end
            S_RESP: begin
                bus.rsp0_valid = ~r_owner;
                bus.rsp1_valid =  r_owner;
                if (r_owner ? bus.rsp1_ready : bus.rsp0_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_acc          = w_rdy0 | w_rdy1;
    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.rsp0_rslt  = r_rslt[0];
    assign bus.rsp0_co    = r_co[0];
    assign bus.rsp0_pari  = r_pari[0];
    assign bus.rsp1_rslt  = r_rslt[1];
    assign bus.rsp1_co    = r_co[1];
    assign bus.rsp1_pari  = r_pari[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_cmd   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_rslt  <= '0;
            r_co    <= '0;
            r_pari  <= '0;
`ifdef ALU_ARB_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            if (w_acc) begin
                r_owner <= w_rdy1;
                r_last  <= w_rdy1;
                r_cmd   <= w_rdy1 ? bus.req1_cmd : bus.req0_cmd;
                r_a     <= w_rdy1 ? bus.req1_a   : bus.req0_a;
                r_b     <= w_rdy1 ? bus.req1_b   : bus.req0_b;
                r_ci    <= w_rdy1 ? bus.req1_ci  : bus.req0_ci;
`ifdef ALU_ARB_LOCK_EN
                r_lock  <= w_rdy1 ? bus.req1_lock : bus.req0_lock;
`endif
            end
            if (r_state == S_EXEC) begin
                r_rslt[r_owner] <= bus.alu_rslt;
                r_co[r_owner]   <= bus.alu_sc_o;
                r_pari[r_owner] <= bus.alu_pari;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model and per-cycle compare.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DW(8), .CMDW(3)) bus ();
    alu_arbiter #(.DW(8), .CMDW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Reference ALU: {parity, carry, result}
    function automatic logic [9:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] t;
        case (c)
            3'd0: t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            3'd1: t = {1'b0, a} - {1'b0, b} - {8'd0, ci};
            3'd2: t = {1'b0, a & b};
            3'd3: t = {1'b0, a ^ b};
            3'd4: t = {1'b0, a | b};
            3'd5: t = {a, ci};
            3'd6: t = {a[0], ci, a[7:1]};
            default: t = {1'b0, b};
        endcase
        return {^t[7:0], t[8], t[7:0]};
    endfunction

    always_comb {bus.alu_pari, bus.alu_sc_o, bus.alu_rslt} = alu_f(bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 executing, 2 holding response
    int          m_phase;
    logic        m_owner, m_last, m_lock, m_ci, m_co, m_pari;
    logic [2:0]  m_cmd;
    logic [7:0]  m_a, m_b, m_rslt;

    function automatic int grant_f();
        logic l0, l1;
        l0 = 1'b0; l1 = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        l0 = bus.req0_lock; l1 = bus.req1_lock;
        if (m_lock) return m_owner ? (bus.req1_valid ? 1 : -1) : (bus.req0_valid ? 0 : -1);
`endif
        if (l0 & l1) return -2;
        if (bus.req0_valid && bus.req1_valid) return m_last ? 0 : 1;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_last <= 1'b1; m_lock <= 1'b0; m_owner <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    int g;
                    g = grant_f();
                    if (g >= 0) begin
                        m_owner <= (g == 1); m_last <= (g == 1); m_phase <= 1;
                        m_cmd <= (g == 1) ? bus.req1_cmd : bus.req0_cmd;
                        m_a   <= (g == 1) ? bus.req1_a   : bus.req0_a;
                        m_b   <= (g == 1) ? bus.req1_b   : bus.req0_b;
                        m_ci  <= (g == 1) ? bus.req1_ci  : bus.req0_ci;
`ifdef ALU_ARB_LOCK_EN
                        m_lock <= (g == 1) ? bus.req1_lock : bus.req0_lock;
`endif
                    end
                end
                1: begin
                    {m_pari, m_co, m_rslt} <= alu_f(m_cmd, m_a, m_b, m_ci);
                    m_phase <= 2;
                end
                default: if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int g;
            g = (!reset && m_phase == 0) ? grant_f() : -1;
            chk("ready", 32'({bus.req1_ready, bus.req0_ready}), 32'({g == 1, g == 0}));
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}),
                32'({m_phase == 2 && m_owner, m_phase == 2 && !m_owner}));
            if (m_phase == 2)
                chk("rsp_data", m_owner ? 32'({bus.rsp1_pari, bus.rsp1_co, bus.rsp1_rslt})
                                        : 32'({bus.rsp0_pari, bus.rsp0_co, bus.rsp0_rslt}),
                    32'({m_pari, m_co, m_rslt}));
            chk("alu_out", 32'({bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i}),
                m_phase == 1 ? 32'({m_cmd, m_a, m_b, m_ci}) : 32'd0);
        end
    end

    task automatic wait_gnt(output int p);
        p = -1;
        for (int i = 0; i < 20 && p < 0; i++) begin
            @(negedge clk);
            if (bus.req0_ready) p = 0;
            else if (bus.req1_ready) p = 1;
        end
        if (p < 0) begin n_checks++; n_errors++; $display("FAIL grant_timeout: got none required a grant"); end
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int port);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = port ? bus.rsp1_valid : bus.rsp0_valid;
        end
        if (!seen) begin n_checks++; n_errors++; $display("FAIL rsp_timeout: port %0d got no rsp_valid", port); end
    endtask

    task automatic set_req(input int port, input logic v, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b, input logic ci);
        if (port == 0) begin bus.req0_valid = v; bus.req0_cmd = c; bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci; end
        else           begin bus.req1_valid = v; bus.req1_cmd = c; bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int p;
        int exp2[4];
        logic [9:0] held;
        exp2 = '{0, 1, 0, 1};
        reset = 1'b1;
        set_req(0, 0, 3'd0, 8'h00, 8'h00, 0);
        set_req(1, 0, 3'd0, 8'h00, 8'h00, 0);
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        bus.req0_lock = 1'b0; bus.req1_lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_co, bus.rsp0_co,
                              bus.rsp1_pari, bus.rsp0_pari, bus.rsp1_rslt, bus.rsp0_rslt}), 32'd0);
        chk("reset_alu", 32'({bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i,
                              bus.busy, bus.req1_ready, bus.req0_ready}), 32'd0);
        cmp_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        // 1: ADD F0+20 -> 10 carry 1, two cycles after accept
        bus.rsp0_ready = 1'b1;
        set_req(0, 1, 3'd0, 8'hF0, 8'h20, 0);
        wait_gnt(p);
        chk("t1_grant", 32'(p), 32'd0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy_exec", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("t1_rsp", 32'({bus.rsp0_valid, bus.rsp0_co, bus.rsp0_rslt}), 32'({1'b1, 1'b1, 8'h10}));

        // 2: both valid from reset, alternating grants
        do_reset();
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        set_req(0, 1, 3'd0, 8'h01, 8'h02, 1);
        set_req(1, 1, 3'd1, 8'h10, 8'h03, 0);
        for (int i = 0; i < 4; i++) begin
            wait_gnt(p);
            chk("t2_grant", 32'(p), 32'(exp2[i]));
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 3: response held while rsp0_ready low
        bus.rsp0_ready = 1'b0;
        set_req(0, 1, 3'd0, 8'h7F, 8'h01, 0);
        set_req(1, 1, 3'd4, 8'h50, 8'h0A, 0);
        wait_gnt(p);
        chk("t3_grant0", 32'(p), 32'd0);
        bus.req0_valid = 1'b0;
        wait_rsp(0);
        held = {bus.rsp0_pari, bus.rsp0_co, bus.rsp0_rslt};
        chk("t3_rslt", 32'(held), 32'({1'b1, 1'b0, 8'h80}));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold", 32'({bus.rsp0_valid, bus.req1_ready, bus.busy, bus.rsp0_pari, bus.rsp0_co, bus.rsp0_rslt}),
                32'({1'b1, 1'b0, 1'b1, held}));
        end
        @(posedge clk); #1 bus.rsp0_ready = 1'b1;
        wait_gnt(p);
        chk("t3_grant1", 32'(p), 32'd1);
        bus.req1_valid = 1'b0;
        wait_rsp(1);
        chk("t3_rsp1", 32'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_rslt}), 32'({1'b1, 1'b0, 8'h5A}));

        // 4: reset during EXEC drops the op
        repeat (2) @(posedge clk); #1;
        set_req(0, 1, 3'd0, 8'h11, 8'h22, 0);
        wait_gnt(p);
        bus.req0_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("t4_reset", 32'({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.alu_inA, bus.alu_inB}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        set_req(1, 1, 3'd3, 8'h3C, 8'h0F, 0);
        wait_gnt(p);
        chk("t4_grant1", 32'(p), 32'd1);
        bus.req1_valid = 1'b0;
        wait_rsp(1);
        chk("t4_rsp1", 32'({bus.rsp0_valid, bus.rsp1_rslt}), 32'({1'b0, 8'h33}));

        // 5: XOR, ALU outputs idle-zero in RESP
        repeat (2) @(posedge clk); #1;
        set_req(0, 1, 3'd3, 8'hA5, 8'h0F, 0);
        wait_gnt(p);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_alu_exec", 32'({bus.alu_cmd, bus.alu_inA, bus.alu_inB}), 32'({3'd3, 8'hA5, 8'h0F}));
        wait_rsp(0);
        chk("t5_rsp", 32'({bus.rsp0_pari, bus.rsp0_rslt}), 32'({1'b0, 8'hAA}));
        chk("t5_alu_resp", 32'({bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i}), 32'd0);

`ifdef ALU_ARB_LOCK_EN
        // 6: lock keeps the grant on port 0 for one extra op
        repeat (2) @(posedge clk); #1;
        do_reset();
        set_req(1, 1, 3'd0, 8'h01, 8'h01, 0);
        set_req(0, 1, 3'd0, 8'hFF, 8'h01, 0);
        bus.req0_lock = 1'b1;
        wait_gnt(p);
        chk("t6_grant_a", 32'(p), 32'd0);
        bus.req0_lock = 1'b0;
        wait_gnt(p);
        chk("t6_grant_b", 32'(p), 32'd0);
        bus.req0_valid = 1'b0;
        wait_gnt(p);
        chk("t6_grant_c", 32'(p), 32'd1);
        bus.req1_valid = 1'b0;
`endif

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
